// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller.
//
// Watches three push-button levels, lets the user freeze the live BCD
// time, step through the sec/min/hour/day fields and increment each field
// with per-field wrap, then commit the edited time back to the datapath.
//
// Ports:
//   CLK, RSTN             clock (rising edge), asynchronous active-low reset
//   KEY_MODE              rising edge enters/leaves edit (leaving = commit)
//   KEY_FIELD             rising edge selects the next field (sec->min->hour->day)
//   KEY_UP                rising edge increments the selected field
//   SEC0..DAY1            live BCD time (0 = units digit, 1 = tens digit)
//   SSEC0..SDAY1          BCD load values to the datapath
//   SET                   datapath loads S* every cycle while high
//   EDIT_FIELD            selected field: 0=sec 1=min 2=hour 3=day
//   ACTIVE                high whenever the controller is out of IDLE
//
// Optional build macro: TIME_SET_CTRL_TIMEOUT_EN adds an inactivity timer;
// after TIMEOUT_CYCLES quiet cycles in EDIT the captured time is restored.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       KEY_MODE,
    input  logic       KEY_FIELD,
    input  logic       KEY_UP,
    input  logic [3:0] SEC0,
    input  logic [3:0] SEC1,
    input  logic [3:0] MIN0,
    input  logic [3:0] MIN1,
    input  logic [3:0] HOUR0,
    input  logic [3:0] HOUR1,
    input  logic [3:0] DAY0,
    input  logic [3:0] DAY1,
    output logic [3:0] SSEC0,
    output logic [3:0] SSEC1,
    output logic [3:0] SMIN0,
    output logic [3:0] SMIN1,
    output logic [3:0] SHOUR0,
    output logic [3:0] SHOUR1,
    output logic [3:0] SDAY0,
    output logic [3:0] SDAY1,
    output logic       SET,
    output logic [1:0] EDIT_FIELD,
    output logic       ACTIVE
);

    typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, RESTORE} state_t;

    // Fields are packed BCD bytes {tens, units}; index 0=sec 1=min 2=hour 3=day.
    localparam logic [3:0][7:0] TIME_RESET = {8'h01, 8'h00, 8'h00, 8'h00};

    state_t          state, state_next;
    logic            mode_q, field_q, up_q;
    logic            mode_edge, field_raw, up_raw, any_edge, field_edge, up_edge;
    logic            timeout_hit;
    logic [3:0][7:0] live, captured;
    logic [3:0][7:0] shadow, shadow_next, snapshot, snapshot_next, out_q;
    logic [1:0]      field, field_next;
    logic            set_q, active_q;

    function automatic logic [7:0] fix_day(input logic [7:0] d);
        return (d == 8'h00 || d > 8'h31) ? 8'h01 : d;
    endfunction

    // BCD increment of one field; wraps inside the field, never carries out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [1:0] f);
        logic [7:0] top;
        logic [7:0] r;
        top = (f == 2'd2) ? 8'h23 : (f == 2'd3) ? 8'h31 : 8'h59;
        if (v >= top)
            r = (f == 2'd3) ? 8'h01 : 8'h00;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return (f == 2'd3) ? fix_day(r) : r;
    endfunction

    assign live = {DAY1, DAY0, HOUR1, HOUR0, MIN1, MIN0, SEC1, SEC0};

    always_comb begin
        captured    = live;
        captured[3] = fix_day(live[3]);
    end

    // Edge detection with fixed priority MODE > FIELD > UP. The raw edges
    // still count as activity for the inactivity timer.
    always_comb begin
        mode_edge  = KEY_MODE  & ~mode_q;
        field_raw  = KEY_FIELD & ~field_q;
        up_raw     = KEY_UP    & ~up_q;
        any_edge   = mode_edge | field_raw | up_raw;
        field_edge = field_raw & ~mode_edge;
        up_edge    = up_raw & ~mode_edge & ~field_raw;
    end

`ifdef TIME_SET_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == EDIT) && !any_edge &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            idle_cnt <= '0;
        else if (state != EDIT || any_edge || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    // Timer not built; the parameter is still read so the port list and
    // parameter set stay identical between builds.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    always_comb begin
        state_next    = state;
        shadow_next   = shadow;
        snapshot_next = snapshot;
        field_next    = field;
        case (state)
            IDLE: begin
                if (mode_edge)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                shadow_next   = captured;
                snapshot_next = captured;
                field_next    = 2'd0;
                state_next    = EDIT;
            end
            EDIT: begin
                if (mode_edge)
                    state_next = IDLE;
                else if (field_edge)
                    field_next = field + 2'd1;
                else if (up_edge)
                    shadow_next[field] = bcd_inc(shadow[field], field);
                else if (timeout_hit)
                    state_next = RESTORE;
            end
            RESTORE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            field_q  <= 1'b0;
            up_q     <= 1'b0;
            shadow   <= TIME_RESET;
            snapshot <= TIME_RESET;
            field    <= 2'd0;
            out_q    <= TIME_RESET;
            set_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_next;
            mode_q   <= KEY_MODE;
            field_q  <= KEY_FIELD;
            up_q     <= KEY_UP;
            shadow   <= shadow_next;
            snapshot <= snapshot_next;
            field    <= field_next;
            // Outputs are registered from next-state so they track the state
            // they describe with no extra cycle of lag.
            out_q    <= (state_next == RESTORE) ? snapshot_next : shadow_next;
            set_q    <= (state_next == EDIT) || (state_next == RESTORE);
            active_q <= (state_next != IDLE);
        end
    end

    assign SSEC0      = out_q[0][3:0];
    assign SSEC1      = out_q[0][7:4];
    assign SMIN0      = out_q[1][3:0];
    assign SMIN1      = out_q[1][7:4];
    assign SHOUR0     = out_q[2][3:0];
    assign SHOUR1     = out_q[2][7:4];
    assign SDAY0      = out_q[3][3:0];
    assign SDAY1      = out_q[3][7:4];
    assign SET        = set_q;
    assign ACTIVE     = active_q;
    assign EDIT_FIELD = field;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    localparam int TO = 20;
`ifdef TIME_SET_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        KEY_MODE = 1'b0, KEY_FIELD = 1'b0, KEY_UP = 1'b0;
    logic [31:0] live_bcd = '0;
    logic [3:0]  SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1;
    logic        SET, ACTIVE;
    logic [1:0]  EDIT_FIELD;

    int checks = 0;
    int errors = 0;

    // Reference model: decimal field values, phase 0=idle 1=capture 2=edit 3=restore.
    int phase, fld, quiet;
    int sh[4], snap[4], live[4];
    bit pm, pf, pu;

    time_set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .KEY_MODE(KEY_MODE), .KEY_FIELD(KEY_FIELD), .KEY_UP(KEY_UP),
        .SEC0(live_bcd[3:0]),   .SEC1(live_bcd[7:4]),
        .MIN0(live_bcd[11:8]),  .MIN1(live_bcd[15:12]),
        .HOUR0(live_bcd[19:16]), .HOUR1(live_bcd[23:20]),
        .DAY0(live_bcd[27:24]), .DAY1(live_bcd[31:28]),
        .SSEC0(SSEC0), .SSEC1(SSEC1), .SMIN0(SMIN0), .SMIN1(SMIN1),
        .SHOUR0(SHOUR0), .SHOUR1(SHOUR1), .SDAY0(SDAY0), .SDAY1(SDAY1),
        .SET(SET), .EDIT_FIELD(EDIT_FIELD), .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] dut_s();
        return {SDAY1, SDAY0, SHOUR1, SHOUR0, SMIN1, SMIN0, SSEC1, SSEC0};
    endfunction

    function automatic logic [35:0] dut_all();
        return {SET, ACTIVE, EDIT_FIELD, dut_s()};
    endfunction

    function automatic logic [35:0] exp_all();
        logic [31:0] s;
        if (phase == 3) s = {bcd(snap[3]), bcd(snap[2]), bcd(snap[1]), bcd(snap[0])};
        else            s = {bcd(sh[3]), bcd(sh[2]), bcd(sh[1]), bcd(sh[0])};
        return {(phase == 2 || phase == 3), (phase != 0), 2'(fld), s};
    endfunction

    function automatic int inc_field(input int f, input int v);
        case (f)
            0, 1:    return (v + 1) % 60;
            2:       return (v + 1) % 24;
            default: return (v >= 31) ? 1 : v + 1;
        endcase
    endfunction

    function automatic void model_reset();
        phase = 0; fld = 0; quiet = 0;
        sh = '{0, 0, 0, 1};
        snap = '{0, 0, 0, 1};
        pm = 0; pf = 0; pu = 0;
    endfunction

    function automatic void model_step(input bit m, input bit f, input bit u);
        bit me, fr, ur, any, hit;
        me = m && !pm; fr = f && !pf; ur = u && !pu;
        any = me || fr || ur;
        case (phase)
            0: if (me) phase = 1;
            1: begin
                for (int i = 0; i < 4; i++) sh[i] = live[i];
                if (sh[3] == 0 || sh[3] > 31) sh[3] = 1;
                snap = sh; fld = 0; quiet = 0; phase = 2;
            end
            2: begin
                hit = TO_EN && !any && quiet == TO - 1;
                if (me)      phase = 0;
                else if (fr) fld = (fld + 1) % 4;
                else if (ur) sh[fld] = inc_field(fld, sh[fld]);
                else if (hit) phase = 3;
                quiet = (any || hit) ? 0 : quiet + 1;
            end
            default: phase = 0;
        endcase
        pm = m; pf = f; pu = u;
    endfunction

    task automatic set_live(input int s, input int mi, input int h, input int d);
        live = '{s, mi, h, d};
        live_bcd = {bcd(d), bcd(h), bcd(mi), bcd(s)};
    endtask

    // Drive key levels for one clock edge; outputs are sampled 1 time unit after it.
    task automatic cycle(input bit m, input bit f, input bit u);
        KEY_MODE = m; KEY_FIELD = f; KEY_UP = u;
        model_step(m, f, u);
        @(posedge CLK); #1;
    endtask

    task automatic press(input bit m, input bit f, input bit u);
        cycle(m, f, u);
        cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        RSTN = 0; KEY_MODE = 0; KEY_FIELD = 0; KEY_UP = 0;
        model_reset();
        #2;
        @(posedge CLK); #1;
        RSTN = 1;
    endtask

    task automatic test_reset();
        RSTN = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({SET, ACTIVE, EDIT_FIELD} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {SET, ACTIVE, EDIT_FIELD});
        end
        checks++;
        if (dut_s() !== 32'h01000000) begin
            errors++; $display("FAIL reset_time got %h exp 01000000", dut_s());
        end
        RSTN = 1;
        cycle(0, 0, 0);
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL reset_idle got %h exp %h", dut_all(), exp_all());
        end
    endtask

    task automatic test_capture();
        set_live(56, 34, 12, 7);
        cycle(1, 0, 0);
        checks++;
        if (SET !== 1'b0) begin
            errors++; $display("FAIL capture_set got %b exp 0", SET);
        end
        cycle(0, 0, 0);
        checks++;
        if ({SET, ACTIVE, EDIT_FIELD, dut_s()} !== {4'b1100, 32'h07123456}) begin
            errors++; $display("FAIL capture_edit got %h exp %h", dut_all(), {4'b1100, 32'h07123456});
        end
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL capture_model got %h exp %h", dut_all(), exp_all());
        end
        cycle(1, 0, 0);
        checks++;
        if ({SET, ACTIVE} !== 2'b00) begin
            errors++; $display("FAIL commit_set got %b exp 00", {SET, ACTIVE});
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_sec_wrap();
        logic [7:0] exp_sec [3] = '{8'h59, 8'h00, 8'h01};
        set_live(58, 34, 12, 7);
        press(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            checks++;
            if ({SMIN1, SMIN0, SSEC1, SSEC0} !== {8'h34, exp_sec[i]}) begin
                errors++; $display("FAIL sec_wrap[%0d] got %h exp %h", i,
                                   {SMIN1, SMIN0, SSEC1, SSEC0}, {8'h34, exp_sec[i]});
            end
            cycle(0, 0, 0);
        end
        press(1, 0, 0);
    endtask

    task automatic test_hold();
        set_live(20, 0, 5, 9);
        press(1, 0, 0);
        repeat (6) cycle(0, 0, 1);
        cycle(0, 0, 0);
        checks++;
        if (dut_s() !== 32'h09050021) begin
            errors++; $display("FAIL key_hold got %h exp 09050021", dut_s());
        end
        press(1, 0, 0);
    endtask

    task automatic test_hour_day();
        set_live(0, 0, 23, 31);
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        checks++;
        if (EDIT_FIELD !== 2'd2) begin
            errors++; $display("FAIL field_hour got %0d exp 2", EDIT_FIELD);
        end
        press(0, 0, 1);
        checks++;
        if (dut_s() !== 32'h31000000) begin
            errors++; $display("FAIL hour_wrap got %h exp 31000000", dut_s());
        end
        press(0, 1, 0);
        press(0, 0, 1);
        checks++;
        if ({EDIT_FIELD, dut_s()} !== {2'd3, 32'h01000000}) begin
            errors++; $display("FAIL day_wrap got %h exp %h", {EDIT_FIELD, dut_s()}, {2'd3, 32'h01000000});
        end
        press(1, 0, 0);
        set_live(0, 0, 0, 0);
        press(1, 0, 0);
        checks++;
        if (dut_s() !== 32'h01000000) begin
            errors++; $display("FAIL day_zero got %h exp 01000000", dut_s());
        end
        press(1, 0, 0);
    endtask

    task automatic test_same_cycle();
        set_live(30, 20, 10, 15);
        press(1, 0, 0);
        cycle(1, 0, 1);
        checks++;
        if ({SET, ACTIVE, dut_s()} !== {2'b00, 32'h15102030}) begin
            errors++; $display("FAIL mode_up_same got %h exp %h", {SET, ACTIVE, dut_s()}, {2'b00, 32'h15102030});
        end
        cycle(0, 0, 0);
        press(1, 1, 0);
        checks++;
        if (EDIT_FIELD !== 2'd0) begin
            errors++; $display("FAIL mode_field_same got %0d exp 0", EDIT_FIELD);
        end
        press(1, 0, 0);
    endtask

    task automatic test_timeout();
        int restore_cnt = 0;
        set_live(7, 30, 8, 15);
        press(1, 0, 0);
        repeat (3) press(0, 0, 1);
        checks++;
        if (dut_s() !== 32'h15083010) begin
            errors++; $display("FAIL to_edit got %h exp 15083010", dut_s());
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0);
            if (SET === 1'b1 && dut_s() === 32'h15083007) restore_cnt++;
            checks++;
            if (dut_all() !== exp_all()) begin
                errors++; $display("FAIL to_seq[%0d] got %h exp %h", i, dut_all(), exp_all());
            end
        end
        checks++;
        if (restore_cnt !== (TO_EN ? 1 : 0)) begin
            errors++; $display("FAIL to_restore_cycles got %0d exp %0d", restore_cnt, TO_EN ? 1 : 0);
        end
        checks++;
        if (SET !== !TO_EN) begin
            errors++; $display("FAIL to_final_set got %b exp %b", SET, !TO_EN);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_edit();
        set_live(42, 11, 9, 3);
        press(1, 0, 0);
        repeat (3) press(0, 0, 1);
        checks++;
        if ({SSEC1, SSEC0} !== 8'h45) begin
            errors++; $display("FAIL pre_reset_sec got %h exp 45", {SSEC1, SSEC0});
        end
        RSTN = 0;
        model_reset();
        #1;
        checks++;
        if ({SET, ACTIVE, EDIT_FIELD, dut_s()} !== {4'b0000, 32'h01000000}) begin
            errors++; $display("FAIL async_reset got %h exp %h", {SET, ACTIVE, EDIT_FIELD, dut_s()}, {4'b0000, 32'h01000000});
        end
        @(posedge CLK); #1;
        RSTN = 1;
        repeat (3) cycle(0, 0, 0);
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL post_reset got %h exp %h", dut_all(), exp_all());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            set_live($urandom_range(0, 59), $urandom_range(0, 59),
                     $urandom_range(0, 23), $urandom_range(0, 39));
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            checks++;
            if (dut_all() !== exp_all()) begin
                errors++; $display("FAIL random[%0d] got %h exp %h", i, dut_all(), exp_all());
            end
        end
    endtask

    initial begin
        model_reset();
        set_live(0, 0, 0, 1);
        test_reset();
        test_capture();
        test_sec_wrap();
        test_hold();
        test_hour_day();
        test_same_cycle();
        test_timeout();
        test_reset_mid_edit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
